// File: rtl/core_ctrl_fsm.sv
// Multi-cycle control sequencer for the PhilosophyV core: fetch, decode, execute, memory and
// writeback, with a single shared memory port driven through a req/ready handshake.
module core_ctrl_fsm #(
    parameter bit HALT_ON_ILLEGAL = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       mem_addr_sel,
    output logic       ir_we,
    output logic       pc_we,
    output logic       ab_we,
    output logic       mdr_we,
    output logic       rf_we,
    output logic [1:0] wb_sel,
    output logic       alu_a_sel,
    output logic [1:0] alu_b_sel,
    output logic       control_override,
    output logic       instret,
    output logic       halt
);

    localparam logic [6:0] OpAluReg = 7'b0110011;
    localparam logic [6:0] OpAluImm = 7'b0010011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StFetch  = 3'd1;
    localparam logic [2:0] StDecode = 3'd2;
    localparam logic [2:0] StExec   = 3'd3;
    localparam logic [2:0] StMem    = 3'd4;
    localparam logic [2:0] StWb     = 3'd5;
    localparam logic [2:0] StHalt   = 3'd6;

    logic [2:0] state_q, state_d;
    logic       is_legal;
    logic       is_load;
    logic       is_store;

    assign is_load  = (opcode == OpLoad);
    assign is_store = (opcode == OpStore);
    assign is_legal = (opcode == OpAluReg) || (opcode == OpAluImm) || is_load || is_store ||
                      (opcode == OpJal) || (opcode == OpJalr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        mem_req          = 1'b0;
        mem_we           = 1'b0;
        mem_addr_sel     = 1'b0;
        ir_we            = 1'b0;
        pc_we            = 1'b0;
        ab_we            = 1'b0;
        mdr_we           = 1'b0;
        rf_we            = 1'b0;
        wb_sel           = 2'd0;
        alu_a_sel        = 1'b0;
        alu_b_sel        = 2'd0;
        control_override = 1'b0;
        instret          = 1'b0;
        halt             = 1'b0;

        case (state_q)
            StIdle: begin
                state_d = StFetch;
            end
            StFetch: begin
                // The ALU computes PC+4 alongside the instruction read.
                mem_req          = 1'b1;
                control_override = 1'b1;
                alu_a_sel        = 1'b1;
                alu_b_sel        = 2'd2;
                if (mem_ready) begin
                    ir_we   = 1'b1;
                    pc_we   = 1'b1;
                    state_d = StDecode;
                end
            end
            StDecode: begin
                ab_we = 1'b1;
                if (is_legal) begin
                    state_d = StExec;
                end else if (HALT_ON_ILLEGAL) begin
                    state_d = StHalt;
                end else begin
                    instret = 1'b1;
                    state_d = StFetch;
                end
            end
            StExec: begin
                case (opcode)
                    OpAluReg: begin
                        state_d = StWb;
                    end
                    OpAluImm: begin
                        alu_b_sel = 2'd1;
                        state_d   = StWb;
                    end
                    OpLoad, OpStore: begin
                        control_override = 1'b1;
                        alu_b_sel        = 2'd1;
                        state_d          = StMem;
                    end
                    OpJal, OpJalr: begin
                        // Link writes the already-incremented PC in the same edge as the jump.
                        control_override = 1'b1;
                        alu_a_sel        = (opcode == OpJal);
                        alu_b_sel        = 2'd1;
                        pc_we            = 1'b1;
                        rf_we            = 1'b1;
                        wb_sel           = 2'd2;
                        instret          = 1'b1;
                        state_d          = StFetch;
                    end
                    default: begin
                        state_d = StFetch;
                    end
                endcase
            end
            StMem: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we       = is_store;
                if (mem_ready) begin
                    if (is_load) begin
                        mdr_we  = 1'b1;
                        state_d = StWb;
                    end else begin
                        instret = 1'b1;
                        state_d = StFetch;
                    end
                end
            end
            StWb: begin
                rf_we   = 1'b1;
                wb_sel  = is_load ? 2'd1 : 2'd0;
                instret = 1'b1;
                state_d = StFetch;
            end
            StHalt: begin
                halt = 1'b1;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

endmodule

// File: tb/tb_core_ctrl_fsm.sv
// Bench for core_ctrl_fsm: per-cycle output traces predicted from each instruction's class and
// the memory wait states chosen for it.
module tb_core_ctrl_fsm;

    localparam logic [6:0] OpAluReg = 7'b0110011;
    localparam logic [6:0] OpAluImm = 7'b0010011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpBad    = 7'b1111111;

    // Packed output vector bit positions.
    localparam int BReq = 15, BWe = 14, BAs = 13, BIr = 12, BPc = 11, BAb = 10, BMdr = 9;
    localparam int BRf = 8, BASel = 5, BCo = 2, BRet = 1, BHalt = 0;

    logic       clk, rst, rst1, mem_ready;
    logic [6:0] opcode;

    logic       a_req, a_we, a_as, a_ir, a_pc, a_ab, a_mdr, a_rf, a_asel, a_co, a_ret, a_halt;
    logic [1:0] a_wb, a_bsel;
    logic       b_req, b_we, b_as, b_ir, b_pc, b_ab, b_mdr, b_rf, b_asel, b_co, b_ret, b_halt;
    logic [1:0] b_wb, b_bsel;

    logic [15:0] obs0, obs1;
    int tests, fails;

    core_ctrl_fsm #(.HALT_ON_ILLEGAL(1'b1)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .mem_req(a_req), .mem_we(a_we), .mem_addr_sel(a_as), .ir_we(a_ir), .pc_we(a_pc),
        .ab_we(a_ab), .mdr_we(a_mdr), .rf_we(a_rf), .wb_sel(a_wb), .alu_a_sel(a_asel),
        .alu_b_sel(a_bsel), .control_override(a_co), .instret(a_ret), .halt(a_halt)
    );

    core_ctrl_fsm #(.HALT_ON_ILLEGAL(1'b0)) dut_nop (
        .clk(clk), .rst(rst1), .opcode(opcode), .mem_ready(mem_ready),
        .mem_req(b_req), .mem_we(b_we), .mem_addr_sel(b_as), .ir_we(b_ir), .pc_we(b_pc),
        .ab_we(b_ab), .mdr_we(b_mdr), .rf_we(b_rf), .wb_sel(b_wb), .alu_a_sel(b_asel),
        .alu_b_sel(b_bsel), .control_override(b_co), .instret(b_ret), .halt(b_halt)
    );

    assign obs0 = {a_req, a_we, a_as, a_ir, a_pc, a_ab, a_mdr, a_rf, a_wb, a_asel, a_bsel,
                   a_co, a_ret, a_halt};
    assign obs1 = {b_req, b_we, b_as, b_ir, b_pc, b_ab, b_mdr, b_rf, b_wb, b_asel, b_bsel,
                   b_co, b_ret, b_halt};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit legal(input logic [6:0] op);
        return op == OpAluReg || op == OpAluImm || op == OpLoad || op == OpStore ||
               op == OpJal || op == OpJalr;
    endfunction

    function automatic logic [15:0] fetch_vec(input bit ready);
        logic [15:0] v;
        v = '0;
        v[BReq] = 1'b1; v[BCo] = 1'b1; v[BASel] = 1'b1; v[4:3] = 2'd2;
        if (ready) begin
            v[BIr] = 1'b1; v[BPc] = 1'b1;
        end
        return v;
    endfunction

    // Builds the expected trace for one instruction and checks it cycle by cycle.
    // Entered and left 1 time unit after a rising edge, with the FSM in FETCH.
    task automatic run_instr(input logic [6:0] op, input int fw, input int mw, input bit on1,
                             input string name);
        logic [15:0] eq[$];
        bit          rq[$];
        logic [15:0] v;
        logic [15:0] got;
        for (int i = 0; i < fw; i++) begin
            eq.push_back(fetch_vec(1'b0)); rq.push_back(1'b0);
        end
        eq.push_back(fetch_vec(1'b1)); rq.push_back(1'b1);
        v = '0; v[BAb] = 1'b1;
        if (!legal(op) && on1) v[BRet] = 1'b1;
        eq.push_back(v); rq.push_back(bit'($urandom_range(0, 1)));
        if (legal(op)) begin
            v = '0;
            if (op == OpAluImm) v[4:3] = 2'd1;
            if (op == OpLoad || op == OpStore) begin
                v[4:3] = 2'd1; v[BCo] = 1'b1;
            end
            if (op == OpJal || op == OpJalr) begin
                v[BASel] = (op == OpJal); v[4:3] = 2'd1; v[BCo] = 1'b1;
                v[BPc] = 1'b1; v[BRf] = 1'b1; v[7:6] = 2'd2; v[BRet] = 1'b1;
            end
            eq.push_back(v); rq.push_back(bit'($urandom_range(0, 1)));
            if (op == OpLoad || op == OpStore) begin
                v = '0; v[BReq] = 1'b1; v[BAs] = 1'b1; v[BWe] = (op == OpStore);
                for (int i = 0; i < mw; i++) begin
                    eq.push_back(v); rq.push_back(1'b0);
                end
                if (op == OpLoad) v[BMdr] = 1'b1;
                else v[BRet] = 1'b1;
                eq.push_back(v); rq.push_back(1'b1);
            end
            if (op == OpAluReg || op == OpAluImm || op == OpLoad) begin
                v = '0; v[BRf] = 1'b1; v[BRet] = 1'b1;
                v[7:6] = (op == OpLoad) ? 2'd1 : 2'd0;
                eq.push_back(v); rq.push_back(bit'($urandom_range(0, 1)));
            end
        end
        opcode = op;
        for (int i = 0; i < eq.size(); i++) begin
            mem_ready = rq[i];
            #1;
            got = on1 ? obs1 : obs0;
            tests++;
            if (got !== eq[i]) begin
                fails++;
                $display("FAIL %s cycle %0d: got %h required %h", name, i, got, eq[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic check0(input logic [15:0] exp, input string name);
        tests++;
        if (obs0 !== exp) begin
            fails++;
            $display("FAIL %s: got %h required %h", name, obs0, exp);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; rst1 = 1'b1; mem_ready = 1'b1; opcode = OpAluReg;
        #1 rst = 1'b1;
        #1 check0(16'h0000, "reset_outputs");
        @(posedge clk); #1;
        rst = 1'b0;
        #1 check0(16'h0000, "idle_after_reset");
        @(posedge clk); #1;
    endtask

    task automatic test_alu_reg();
        run_instr(OpAluReg, 0, 0, 1'b0, "alu_reg");
        run_instr(OpAluImm, 1, 0, 1'b0, "alu_imm");
    endtask

    task automatic test_load_wait();
        run_instr(OpLoad, 0, 3, 1'b0, "load_wait3");
    endtask

    task automatic test_store();
        run_instr(OpStore, 0, 0, 1'b0, "store");
    endtask

    task automatic test_jal();
        run_instr(OpJal, 0, 0, 1'b0, "jal");
        run_instr(OpJalr, 2, 0, 1'b0, "jalr");
    endtask

    task automatic test_back_to_back();
        logic [6:0] ops[6];
        ops = '{OpAluReg, OpAluImm, OpLoad, OpStore, OpJal, OpJalr};
        for (int n = 0; n < 30; n++) begin
            run_instr(ops[$urandom_range(0, 5)], int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 3)), 1'b0, "random_stream");
        end
    endtask

    task automatic test_reset_mid_fetch();
        mem_ready = 1'b0;
        #1 check0(fetch_vec(1'b0), "fetch_wait");
        #1 rst = 1'b1;
        #1 check0(16'h0000, "async_reset_mid_fetch");
        @(posedge clk); #1;
        check0(16'h0000, "held_in_reset");
        rst = 1'b0; mem_ready = 1'b1;
        #1 check0(16'h0000, "idle_after_mid_reset");
        @(posedge clk); #1;
        run_instr(OpStore, 1, 2, 1'b0, "store_after_reset");
    endtask

    task automatic test_halt();
        logic [15:0] hv;
        hv = '0; hv[BHalt] = 1'b1;
        run_instr(OpBad, 0, 0, 1'b0, "illegal_decode");
        for (int i = 0; i < 100; i++) begin
            mem_ready = bit'($urandom_range(0, 1));
            #1 check0(hv, "halt_sticky");
            @(posedge clk); #1;
        end
        rst = 1'b1;
        #1 check0(16'h0000, "reset_from_halt");
        @(posedge clk); #1;
        rst = 1'b0;
        #1 check0(16'h0000, "idle_after_halt");
        @(posedge clk); #1;
        run_instr(OpAluReg, 0, 0, 1'b0, "alu_after_halt");
    endtask

    task automatic test_nop_illegal();
        rst1 = 1'b0;
        #1;
        tests++;
        if (obs1 !== 16'h0000) begin
            fails++;
            $display("FAIL nop_idle: got %h required %h", obs1, 16'h0000);
        end
        @(posedge clk); #1;
        run_instr(OpBad, 0, 0, 1'b1, "illegal_nop");
        run_instr(OpAluImm, 2, 0, 1'b1, "nop_then_alu");
        run_instr(7'h00, 1, 0, 1'b1, "illegal_nop_zero");
        run_instr(OpLoad, 0, 1, 1'b1, "nop_then_load");
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_alu_reg();
        test_load_wait();
        test_store();
        test_jal();
        test_back_to_back();
        test_reset_mid_fetch();
        test_halt();
        test_nop_illegal();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
